// File: rtl/cavlc_pkg.sv
// Shared types and nC helpers for the CAVLC nC controller.
package cavlc_pkg;

  typedef logic [4:0] tc_t;

  typedef enum logic [1:0] {TBL_0_2, TBL_2_4, TBL_4_8, TBL_FLC} tbl_sel_e;

  typedef enum logic [1:0] {IDLE, LOOKUP, RUN, COMMIT} nc_state_e;

  localparam tc_t TC_MAX = 5'd16;

  // Rounded mean when both neighbours exist; a 6-bit sum keeps 16+16+1 exact.
  function automatic tc_t calc_nc(tc_t na, tc_t nb, logic avail_a, logic avail_b);
    logic [5:0] sum;
    sum = {1'b0, na} + {1'b0, nb} + 6'd1;
    case ({avail_a, avail_b})
      2'b11:   calc_nc = sum[5:1];
      2'b10:   calc_nc = na;
      2'b01:   calc_nc = nb;
      default: calc_nc = '0;
    endcase
  endfunction

  function automatic tbl_sel_e nc_to_tbl(tc_t nc);
    if (nc < 5'd2)      nc_to_tbl = TBL_0_2;
    else if (nc < 5'd4) nc_to_tbl = TBL_2_4;
    else if (nc < 5'd8) nc_to_tbl = TBL_4_8;
    else                nc_to_tbl = TBL_FLC;
  endfunction

endpackage

// File: rtl/cavlc_top_linebuf.sv
// Top-neighbour line buffer: one 20-bit word (bottom-row tcs) per MB column, 1-cycle sync read.
module cavlc_top_linebuf #(
  parameter int DEPTH = 120,
  parameter int AW    = 7,
  parameter int DW    = 20
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          re_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  // Read data holds between reads so the whole RUN phase sees the LOOKUP result.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/cavlc_nc_ctrl.sv
// Per-4x4 nC prediction and coeff_token table select, sequenced over a frame of luma MBs.
// Optional CAVLC_STATS_EN adds per-frame tc sum and zero-block counters.
module cavlc_nc_ctrl
  import cavlc_pkg::*;
#(
  parameter int MB_W_MAX = 120,
  parameter int MB_H_MAX = 68
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  cfg_mb_w,
  input  logic [6:0]  cfg_mb_h,
  input  logic        sof,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  tc_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_tc,
  output logic [4:0]  out_nc,
  output logic [1:0]  out_tbl,
  output logic [3:0]  out_blk,
  output logic        out_eof,
  output logic        busy
`ifdef CAVLC_STATS_EN
  ,
  output logic [19:0] stat_nz_sum,
  output logic [13:0] stat_zero_blk
`endif
);

  localparam int XW = (MB_W_MAX > 1) ? $clog2(MB_W_MAX) : 1;
  localparam int YW = (MB_H_MAX > 1) ? $clog2(MB_H_MAX) : 1;

  nc_state_e       state_q, state_d;
  logic [6:0]      w_q, h_q;
  logic [XW-1:0]   mb_x_q;
  logic [YW-1:0]   mb_y_q;
  logic [3:0]      blk_q;
  logic [15:0][4:0] cur_q;
  logic [3:0][4:0] left_q;
  logic [3:0][4:0] top_rd;
  logic [3:0][4:0] bot_row;

  logic            out_valid_q, out_eof_q;
  tc_t             out_tc_q, out_nc_q;
  tbl_sel_e        out_tbl_q;
  logic [3:0]      out_blk_q;

  logic            accept, sof_acc, last_x, last_y, last_mb, lb_re, lb_we;
  logic [1:0]      bx, by, bx_m1, by_m1;
  tc_t             tc_c, na, nb, nc_c;
  logic            avail_a, avail_b;

  assign sof_acc = (state_q == IDLE) && sof;
  assign accept  = in_valid && in_ready;
  assign tc_c    = (tc_in > TC_MAX) ? TC_MAX : tc_in;
  assign last_x  = (mb_x_q == XW'(w_q - 7'd1));
  assign last_y  = (mb_y_q == YW'(h_q - 7'd1));
  assign last_mb = last_x && last_y;

  // blkIdx interleaves x/y bits: x = {b2,b0}, y = {b3,b1}.
  assign bx    = {blk_q[2], blk_q[0]};
  assign by    = {blk_q[3], blk_q[1]};
  assign bx_m1 = bx - 2'd1;
  assign by_m1 = by - 2'd1;

  assign na      = (bx != 2'd0) ? cur_q[{by, bx_m1}] : left_q[by];
  assign nb      = (by != 2'd0) ? cur_q[{by_m1, bx}] : top_rd[bx];
  assign avail_a = (bx != 2'd0) || (mb_x_q != '0);
  assign avail_b = (by != 2'd0) || (mb_y_q != '0);
  assign nc_c    = calc_nc(na, nb, avail_a, avail_b);

  always_comb begin
    for (int i = 0; i < 4; i++) bot_row[i] = cur_q[4'(12 + i)];
  end

  cavlc_top_linebuf #(.DEPTH(MB_W_MAX), .AW(XW), .DW(20)) u_linebuf (
    .clk_i   (clk),
    .rst_ni  (rst),
    .re_i    (lb_re),
    .we_i    (lb_we),
    .addr_i  (mb_x_q),
    .wdata_i (bot_row),
    .rdata_o (top_rd)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (sof) state_d = LOOKUP;
      LOOKUP:  state_d = RUN;
      RUN:     if (accept && blk_q == 4'd15) state_d = COMMIT;
      COMMIT:  state_d = last_mb ? IDLE : LOOKUP;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    lb_re    = 1'b0;
    lb_we    = 1'b0;
    case (state_q)
      LOOKUP: begin busy = 1'b1; lb_re = 1'b1; end
      RUN:    begin busy = 1'b1; in_ready = !out_valid_q || out_ready; end
      COMMIT: begin busy = 1'b1; lb_we = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_q    <= '0;
      h_q    <= '0;
      mb_x_q <= '0;
      mb_y_q <= '0;
      blk_q  <= '0;
      cur_q  <= '0;
      left_q <= '0;
    end else begin
      if (sof_acc) begin
        w_q    <= cfg_mb_w;
        h_q    <= cfg_mb_h;
        mb_x_q <= '0;
        mb_y_q <= '0;
        blk_q  <= '0;
      end
      if (accept) begin
        cur_q[{by, bx}] <= tc_c;
        blk_q           <= blk_q + 4'd1;
      end
      // Right column becomes the next MB's left neighbours; the stale copy at a row
      // wrap is harmless because mb_x==0 marks left as unavailable.
      if (state_q == COMMIT) begin
        for (int i = 0; i < 4; i++) left_q[i] <= cur_q[4'(i * 4 + 3)];
        if (last_x) begin
          mb_x_q <= '0;
          mb_y_q <= mb_y_q + YW'(1);
        end else begin
          mb_x_q <= mb_x_q + XW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      out_tc_q    <= '0;
      out_nc_q    <= '0;
      out_tbl_q   <= TBL_0_2;
      out_blk_q   <= '0;
      out_eof_q   <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_tc_q    <= tc_c;
      out_nc_q    <= nc_c;
      out_tbl_q   <= nc_to_tbl(nc_c);
      out_blk_q   <= blk_q;
      out_eof_q   <= (blk_q == 4'd15) && last_mb;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_tc    = out_tc_q;
  assign out_nc    = out_nc_q;
  assign out_tbl   = out_tbl_q;
  assign out_blk   = out_blk_q;
  assign out_eof   = out_eof_q;

`ifdef CAVLC_STATS_EN
  logic [19:0] nz_sum_q;
  logic [13:0] zero_blk_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      nz_sum_q   <= '0;
      zero_blk_q <= '0;
    end else if (sof_acc) begin
      nz_sum_q   <= '0;
      zero_blk_q <= '0;
    end else if (accept) begin
      nz_sum_q   <= nz_sum_q + 20'(tc_c);
      zero_blk_q <= zero_blk_q + 14'(tc_c == 5'd0);
    end
  end

  assign stat_nz_sum   = nz_sum_q;
  assign stat_zero_blk = zero_blk_q;
`endif

endmodule

// File: tb/tb_cavlc_nc_ctrl.sv
// Scoreboard bench for cavlc_nc_ctrl: a frame-grid reference model feeds an expected queue.
module tb_cavlc_nc_ctrl;

  logic       clk = 1'b0, rst = 1'b0, sof = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [6:0] cfg_mb_w = '0, cfg_mb_h = '0;
  logic [4:0] tc_in = '0;
  logic       in_ready, out_valid, out_eof, busy;
  logic [4:0] out_tc, out_nc;
  logic [1:0] out_tbl;
  logic [3:0] out_blk;
`ifdef CAVLC_STATS_EN
  logic [19:0] stat_nz_sum;
  logic [13:0] stat_zero_blk;
`endif

  cavlc_nc_ctrl dut (
    .clk(clk), .rst(rst), .cfg_mb_w(cfg_mb_w), .cfg_mb_h(cfg_mb_h), .sof(sof),
    .in_valid(in_valid), .in_ready(in_ready), .tc_in(tc_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_tc(out_tc), .out_nc(out_nc),
    .out_tbl(out_tbl), .out_blk(out_blk), .out_eof(out_eof), .busy(busy)
`ifdef CAVLC_STATS_EN
    , .stat_nz_sum(stat_nz_sum), .stat_zero_blk(stat_zero_blk)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {int tc; int nc; int tbl; int blk; int eof;} exp_t;
  exp_t q[$];
  int   grid[int];          // frame-level 4x4 grid, key = Y*4096 + X
  int   checks = 0, errors = 0;
  int   stall_req = 0;
  int   fr_sum = 0, fr_zero = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int gval(int x, int y);
    if (grid.exists(y * 4096 + x)) return grid[y * 4096 + x];
    return 0;
  endfunction

  // Neighbours looked up in frame coordinates: left is (X-1,Y), top is (X,Y-1).
  function automatic exp_t model(int mbx, int mby, int blk, int tc, int w, int h);
    exp_t e;
    int bx, by, x, y, na, nb;
    bx = ((blk >> 2) & 1) * 2 + (blk & 1);
    by = ((blk >> 3) & 1) * 2 + ((blk >> 1) & 1);
    x = mbx * 4 + bx;
    y = mby * 4 + by;
    e.tc  = (tc > 16) ? 16 : tc;
    na    = gval(x - 1, y);
    nb    = gval(x, y - 1);
    if (x > 0 && y > 0) e.nc = (na + nb + 1) / 2;
    else if (x > 0)     e.nc = na;
    else if (y > 0)     e.nc = nb;
    else                e.nc = 0;
    e.tbl = (e.nc < 2) ? 0 : (e.nc < 4) ? 1 : (e.nc < 8) ? 2 : 3;
    e.blk = blk;
    e.eof = (blk == 15 && mbx == w - 1 && mby == h - 1) ? 1 : 0;
    return e;
  endfunction

  // Monitor: whenever output is valid it must equal the queue head; pop on handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (stall_req > 0) begin
        out_ready = 1'b0;
        stall_req--;
      end else begin
        out_ready = ($urandom_range(0, 3) != 0);
      end
      #1;
      if (rst && out_valid) begin
        if (q.size() == 0) begin
          chk("spurious_out", q.size(), 1);
        end else begin
          chk("out_tc",  int'(out_tc),  q[0].tc);
          chk("out_nc",  int'(out_nc),  q[0].nc);
          chk("out_tbl", int'(out_tbl), q[0].tbl);
          chk("out_blk", int'(out_blk), q[0].blk);
          chk("out_eof", int'(out_eof), q[0].eof);
          if (out_ready) void'(q.pop_front());
          else           chk("in_ready_stall", int'(in_ready), 0);
        end
      end
    end
  end

  task automatic send(input int mbx, input int mby, input int blk, input int tc,
                      input int w, input int h);
    exp_t e;
    int   budget;
    @(negedge clk);
    if ($urandom_range(0, 3) == 0) begin
      in_valid = 1'b0;
      repeat ($urandom_range(1, 2)) @(negedge clk);
    end
    e = model(mbx, mby, blk, tc, w, h);
    grid[(mby * 4 + ((blk >> 3) & 1) * 2 + ((blk >> 1) & 1)) * 4096 +
         mbx * 4 + ((blk >> 2) & 1) * 2 + (blk & 1)] = e.tc;
    in_valid = 1'b1;
    tc_in    = 5'(tc);
    #1;
    budget = 0;
    while (!in_ready && budget < 100) begin
      @(negedge clk);
      #1;
      budget++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", int'(in_ready), 1);
      in_valid = 1'b0;
      return;
    end
    q.push_back(e);
    fr_sum  += e.tc;
    fr_zero += (e.tc == 0) ? 1 : 0;
    @(posedge clk);
  endtask

  task automatic frame_start(input int w, input int h);
    @(negedge clk);
    in_valid = 1'b0;
    sof      = 1'b1;
    cfg_mb_w = 7'(w);
    cfg_mb_h = 7'(h);
    @(negedge clk);
    sof      = 1'b0;
    cfg_mb_w = 7'($urandom_range(1, 127));
    cfg_mb_h = 7'($urandom_range(1, 127));
    fr_sum   = 0;
    fr_zero  = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b0;
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy",      int'(busy),      0);
    chk("rst_in_ready",  int'(in_ready),  0);
    chk("rst_out_nc",    int'(out_nc),    0);
    chk("rst_out_tc",    int'(out_tc),    0);
    chk("rst_out_blk",   int'(out_blk),   0);
    chk("rst_out_tbl",   int'(out_tbl),   0);
    chk("rst_out_eof",   int'(out_eof),   0);
    q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // mode: 0 zeros, 1 tc=blkIdx, 2 all 9, 3 random (some >16), 4 eight 16s then eight 0s
  task automatic run_frame(input int w, input int h, input int mode,
                           input int abort_mb, input bit glitch, input bit stall);
    int tc;
    frame_start(w, h);
    for (int my = 0; my < h; my++) begin
      for (int mx = 0; mx < w; mx++) begin
        for (int b = 0; b < 16; b++) begin
          if (my * w + mx == abort_mb && b == 5) begin
            do_reset();
            return;
          end
          if (glitch && mx == 0 && my == 0 && b == 3) begin
            @(negedge clk);
            in_valid = 1'b0;
            sof = 1'b1;
            cfg_mb_w = 7'd5;
            cfg_mb_h = 7'd5;
            @(negedge clk);
            sof = 1'b0;
          end
          if (stall && mx == 0 && my == 0 && b == 6) stall_req = 5;
          case (mode)
            0: tc = 0;
            1: tc = b;
            2: tc = 9;
            4: tc = (b < 8) ? 16 : 0;
            default: tc = ($urandom_range(0, 9) == 0) ? $urandom_range(17, 31)
                                                      : $urandom_range(0, 16);
          endcase
          send(mx, my, b, tc, w, h);
        end
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("busy_commit", int'(busy), 1);
    @(negedge clk);
    #1;
    chk("busy_drop", int'(busy), 0);
`ifdef CAVLC_STATS_EN
    chk("stat_nz_sum",   int'(stat_nz_sum),   fr_sum);
    chk("stat_zero_blk", int'(stat_zero_blk), fr_zero);
`endif
  endtask

  initial begin
    int budget;
    #2;
    chk("init_out_valid", int'(out_valid), 0);
    chk("init_busy",      int'(busy),      0);
    chk("init_in_ready",  int'(in_ready),  0);
    chk("init_out_nc",    int'(out_nc),    0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    run_frame(1, 1, 0, -1, 1'b0, 1'b0);
    run_frame(1, 1, 1, -1, 1'b0, 1'b0);
    run_frame(2, 2, 2, -1, 1'b0, 1'b0);
    run_frame(3, 2, 3, -1, 1'b1, 1'b1);
    run_frame(1, 1, 4, -1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      run_frame($urandom_range(1, 4), $urandom_range(1, 3), 3, -1, 1'b0, i[0]);
    run_frame(2, 1, 3, 1, 1'b0, 1'b0);
    run_frame(1, 1, 1, -1, 1'b0, 1'b0);
    run_frame(1, 3, 3, -1, 1'b0, 1'b0);

    budget = 0;
    while (q.size() != 0 && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    chk("drain", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
